// File: rtl/condicionador_botao.sv
// ============================================================================
// Module   : condicionador_botao
// Brief    : Push-button conditioner: 2-flop synchronizer, debounce FSM,
//            press/release strobes and press counter. Define AUTO_REPEAT_EN
//            to enable hold-to-repeat strobes on btn_pulso.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module condicionador_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 1000000,
  parameter int unsigned REPEAT_ATRASO   = 25000000,
  parameter int unsigned REPEAT_PERIODO  = 10000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_IN,
  output logic       btn_estavel,
  output logic       btn_pulso,
  output logic       btn_solto_pulso,
  output logic [7:0] contador_cliques
);

  localparam int          CNT_W   = 24;
  localparam logic [23:0] DEB_FIM = 24'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTO = 2'd3
  } estado_t;

  if (DEBOUNCE_CICLOS < 2 || DEBOUNCE_CICLOS > 24'hFFFFFF ||
      REPEAT_ATRASO < 1 || REPEAT_PERIODO < 1) begin : g_param_invalid
    $error("condicionador_botao: parameter out of range");
  end

  // Synchronizer flops reset to 1 so a released key is the power-up view.
  logic key_meta;
  logic key_sync2;
  logic key_sinc;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta  <= 1'b1;
      key_sync2 <= 1'b1;
    end else begin
      key_meta  <= KEY_IN;
      key_sync2 <= key_meta;
    end
  end

  assign key_sinc = ~key_sync2;

  estado_t           state;
  estado_t           next_state;
  logic [CNT_W-1:0]  deb_cnt;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              press_evt;
  logic              release_evt;
  logic              pulse_evt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= SOLTO;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    unique case (state)
      SOLTO: begin
        if (key_sinc) begin
          next_state = CONFIRMA_PRESS;
          cnt_clear  = 1'b1;
        end
      end
      CONFIRMA_PRESS: begin
        if (!key_sinc) begin
          next_state = SOLTO;
          cnt_clear  = 1'b1;
        end else if (deb_cnt == DEB_FIM) begin
          next_state = PRESSIONADO;
          press_evt  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!key_sinc) begin
          next_state = CONFIRMA_SOLTO;
          cnt_clear  = 1'b1;
        end
      end
      CONFIRMA_SOLTO: begin
        if (key_sinc) begin
          next_state = PRESSIONADO;
          cnt_clear  = 1'b1;
        end else if (deb_cnt == DEB_FIM) begin
          next_state  = SOLTO;
          release_evt = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        next_state = SOLTO;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Saturates so a stuck count can never alias back into the confirm window.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_cnt <= '0;
    end else if (cnt_clear) begin
      deb_cnt <= '0;
    end else if (cnt_inc && (deb_cnt != {CNT_W{1'b1}})) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] ATRASO_FIM  = 32'(REPEAT_ATRASO - 1);
  localparam logic [31:0] PERIODO_FIM = 32'(REPEAT_PERIODO - 1);

  logic [31:0] hold_cnt;
  logic        repetindo;
  logic        repeat_evt;

  always_comb begin
    repeat_evt = 1'b0;
    if (state == PRESSIONADO) begin
      repeat_evt = repetindo ? (hold_cnt == PERIODO_FIM) : (hold_cnt == ATRASO_FIM);
    end
  end

  // First repeat waits the long delay, later ones use the shorter period.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt  <= '0;
      repetindo <= 1'b0;
    end else if (state != PRESSIONADO) begin
      hold_cnt  <= '0;
      repetindo <= 1'b0;
    end else if (repeat_evt) begin
      hold_cnt  <= '0;
      repetindo <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign pulse_evt = press_evt | repeat_evt;
`else
  assign pulse_evt = press_evt;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_pulso        <= 1'b0;
      btn_solto_pulso  <= 1'b0;
      contador_cliques <= 8'd0;
    end else begin
      btn_pulso       <= pulse_evt;
      btn_solto_pulso <= release_evt;
      if (pulse_evt) begin
        contador_cliques <= contador_cliques + 8'd1;
      end
    end
  end

  assign btn_estavel = (state == PRESSIONADO) || (state == CONFIRMA_SOLTO);

endmodule

`default_nettype wire

// File: tb/tb_condicionador_botao.sv
// ============================================================================
// Module   : tb_condicionador_botao
// Brief    : Directed self-checking bench for condicionador_botao.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_condicionador_botao;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic       btn_estavel;
  logic       btn_pulso;
  logic       btn_solto_pulso;
  logic [7:0] contador_cliques;

  int errors;
  int checks;
  int pulse_total;
  int excl_hits;

  condicionador_botao #(
    .DEBOUNCE_CICLOS(4),
    .REPEAT_ATRASO  (10),
    .REPEAT_PERIODO (3)
  ) dut (
    .CLOCK_50        (clk),
    .RESET_N         (rst_n),
    .KEY_IN          (key),
    .btn_estavel     (btn_estavel),
    .btn_pulso       (btn_pulso),
    .btn_solto_pulso (btn_solto_pulso),
    .contador_cliques(contador_cliques)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_pulso) pulse_total++;
    if (btn_pulso && btn_solto_pulso) excl_hits++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [63:0] pmask;
  logic [63:0] smask;
  logic [63:0] exp_pmask;
  logic        est_seen;
  int          pulses_before;

  initial begin
    errors      = 0;
    checks      = 0;
    pulse_total = 0;
    excl_hits   = 0;
    key         = 1'b1;
    rst_n       = 1'b0;

    // Reset state
    step(3);
    check("rst_estavel", {63'd0, btn_estavel}, 64'd0);
    check("rst_pulso", {63'd0, btn_pulso}, 64'd0);
    check("rst_solto", {63'd0, btn_solto_pulso}, 64'd0);
    check("rst_contador", {56'd0, contador_cliques}, 64'd0);
    rst_n = 1'b1;
    step(5);

    // Bounce: low 2, high 1, low 2, high
    pmask    = '0;
    est_seen = 1'b0;
    key      = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      pmask[k] = btn_pulso;
      est_seen = est_seen | btn_estavel;
      if (k == 2) key = 1'b1;
      if (k == 3) key = 1'b0;
      if (k == 5) key = 1'b1;
    end
    check("bounce_pulso", pmask, 64'd0);
    check("bounce_estavel", {63'd0, est_seen}, 64'd0);
    check("bounce_contador", {56'd0, contador_cliques}, 64'd0);

    // Clean press held to k=24, then release
    pmask = '0;
    smask = '0;
    key   = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step(1);
      pmask[k] = btn_pulso;
      smask[k] = btn_solto_pulso;
      if (k == 6)  check("press_estavel_k6", {63'd0, btn_estavel}, 64'd0);
      if (k == 7)  check("press_estavel_k7", {63'd0, btn_estavel}, 64'd1);
      if (k == 20) check("press_estavel_k20", {63'd0, btn_estavel}, 64'd1);
      if (k == 30) check("rel_estavel_k30", {63'd0, btn_estavel}, 64'd1);
      if (k == 31) check("rel_estavel_k31", {63'd0, btn_estavel}, 64'd0);
      if (k == 24) key = 1'b1;
    end
    exp_pmask = 64'd1 << 7;
`ifdef AUTO_REPEAT_EN
    exp_pmask = exp_pmask | (64'd1 << 17) | (64'd1 << 20) | (64'd1 << 23) | (64'd1 << 26);
    check("press_contador", {56'd0, contador_cliques}, 64'd5);
`else
    check("press_contador", {56'd0, contador_cliques}, 64'd1);
`endif
    check("press_pulso_mask", pmask, exp_pmask);
    check("rel_solto_mask", smask, 64'd1 << 31);

    // Wrap: fresh reset, then 256 clean presses
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    pulses_before = pulse_total;
    for (int p = 0; p < 256; p++) begin
      key = 1'b0;
      step(10);
      key = 1'b1;
      step(10);
      if (p == 254) check("wrap_contador_255", {56'd0, contador_cliques}, 64'd255);
    end
    check("wrap_contador_0", {56'd0, contador_cliques}, 64'd0);
    check("wrap_pulse_count", 64'(pulse_total - pulses_before), 64'd256);

    // Reset during hold, key stays pressed
    key = 1'b0;
    step(12);
    check("hold_contador_pre", {56'd0, contador_cliques}, 64'd1);
    check("hold_estavel_pre", {63'd0, btn_estavel}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("hold_rst_estavel", {63'd0, btn_estavel}, 64'd0);
    check("hold_rst_contador", {56'd0, contador_cliques}, 64'd0);
    check("hold_rst_pulso", {62'd0, btn_pulso, btn_solto_pulso}, 64'd0);
    step(1);
    rst_n = 1'b1;
    pmask = '0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      pmask[k] = btn_pulso;
    end
    check("hold_repress_mask", pmask, 64'd1 << 7);
    check("hold_repress_contador", {56'd0, contador_cliques}, 64'd1);
    key = 1'b1;
    step(12);

    check("pulse_exclusive", 64'(excl_hits), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
